int_sequencer: RTL and testbench

- Interrupt/reset sequencer for the 6502 core; sits directly upstream of the program counter high and low registers.
- Arbitrates RESET, NMI, IRQ and BRK, runs the 7-cycle entry sequence (dummy, push PCH, push PCL, push P, vector lo, vector hi), and drives the one-cycle setreset/setirq/setnmi strobes that load the PC registers with the vector page.
- Also supplies the vector-address low byte and the push/mask control strobes.

---
 rtl/int_sequencer_if.sv | 40 ++++
 rtl/int_sequencer.sv | 166 ++++++++++++++++
 tb/tb_int_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_sequencer_if.sv
// ---------------------------------------------------------------------------
// int_sequencer_if : core <-> interrupt sequencer handshake and control bus
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface int_sequencer_if;
  logic       rdy;
  logic       sync;
  logic       brk;
  logic       nmi_n;
  logic       irq_n;
  logic       iflag;
  logic       busy;
  logic       pcinc_inh;
  logic       push_pch;
  logic       push_pcl;
  logic       push_p;
  logic       bflag;
  logic       wr_inh;
  logic       setreset;
  logic       setnmi;
  logic       setirq;
  logic [7:0] vec_lo;
  logic       set_i;

  modport slave (
    input  rdy, sync, brk, nmi_n, irq_n, iflag,
    output busy, pcinc_inh, push_pch, push_pcl, push_p, bflag, wr_inh,
           setreset, setnmi, setirq, vec_lo, set_i
  );

  modport master (
    output rdy, sync, brk, nmi_n, irq_n, iflag,
    input  busy, pcinc_inh, push_pch, push_pcl, push_p, bflag, wr_inh,
           setreset, setnmi, setirq, vec_lo, set_i
  );
endinterface

`default_nettype wire

// File: rtl/int_sequencer.sv
// ---------------------------------------------------------------------------
// int_sequencer : 6502 RESET/NMI/IRQ/BRK arbitration and 7-cycle entry sequence
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module int_sequencer #(
  parameter logic [7:0] NMI_VEC = 8'hFA,
  parameter logic [7:0] RES_VEC = 8'hFC,
  parameter logic [7:0] IRQ_VEC = 8'hFE
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  int_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_S1 = 3'd1, ST_S2 = 3'd2, ST_S3 = 3'd3,
    ST_S4   = 3'd4, ST_S5 = 3'd5, ST_S6 = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0, SRC_RES = 3'd1, SRC_NMI = 3'd2, SRC_IRQ = 3'd3, SRC_BRK = 3'd4
  } src_t;

  state_t     r_state;
  src_t       r_src;
  logic       r_res_pend;
  logic       r_nmi_pend;
  logic       r_nmi_prev;
  logic       r_busy;
  logic       r_pcinc_inh;
  logic       r_push_pch;
  logic       r_push_pcl;
  logic       r_push_p;
  logic       r_bflag;
  logic       r_wr_inh;
  logic       r_setreset;
  logic       r_setnmi;
  logic       r_setirq;
  logic [7:0] r_vec_lo;
  logic       r_set_i;

  logic       w_nmi_edge;
  logic       w_nmi_pend;
  logic       w_irq_req;
  logic       w_take_nmi;
  src_t       w_arb;

  assign w_nmi_edge = r_nmi_prev & ~bus.nmi_n;
  // An edge seen this cycle counts as pending for arbitration and hijack.
  assign w_nmi_pend = r_nmi_pend | w_nmi_edge;
  assign w_irq_req  = ~bus.irq_n & ~bus.iflag;
  assign w_take_nmi = (r_state == ST_S4) && (r_src != SRC_RES) && w_nmi_pend;

  always_comb begin
    w_arb = SRC_NONE;
    if (r_res_pend)      w_arb = SRC_RES;
    else if (bus.sync) begin
      if (w_nmi_pend)    w_arb = SRC_NMI;
      else if (bus.brk)  w_arb = SRC_BRK;
      else if (w_irq_req) w_arb = SRC_IRQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_src       <= SRC_NONE;
      r_res_pend  <= 1'b1;
      r_nmi_pend  <= 1'b0;
      r_nmi_prev  <= 1'b1;
      r_busy      <= 1'b0;
      r_pcinc_inh <= 1'b0;
      r_push_pch  <= 1'b0;
      r_push_pcl  <= 1'b0;
      r_push_p    <= 1'b0;
      r_bflag     <= 1'b0;
      r_wr_inh    <= 1'b0;
      r_setreset  <= 1'b0;
      r_setnmi    <= 1'b0;
      r_setirq    <= 1'b0;
      r_vec_lo    <= 8'h00;
      r_set_i     <= 1'b0;
    end else if (bus.rdy) begin
      r_nmi_prev <= bus.nmi_n;
      r_nmi_pend <= w_nmi_pend & ~w_take_nmi;
      case (r_state)
        ST_IDLE: begin
          if (w_arb != SRC_NONE) begin
            r_state     <= ST_S1;
            r_src       <= w_arb;
            r_busy      <= 1'b1;
            r_pcinc_inh <= 1'b1;
            r_bflag     <= (w_arb == SRC_BRK);
          end
        end
        ST_S1: begin
          r_state    <= ST_S2;
          r_push_pch <= 1'b1;
          r_wr_inh   <= (r_src == SRC_RES);
        end
        ST_S2: begin
          r_state    <= ST_S3;
          r_push_pch <= 1'b0;
          r_push_pcl <= 1'b1;
        end
        ST_S3: begin
          r_state    <= ST_S4;
          r_push_pcl <= 1'b0;
          r_push_p   <= 1'b1;
        end
        ST_S4: begin
          r_state  <= ST_S5;
          r_push_p <= 1'b0;
          r_wr_inh <= 1'b0;
          r_bflag  <= 1'b0;
          if (r_src == SRC_RES) begin
            r_vec_lo   <= RES_VEC;
            r_setreset <= 1'b1;
            r_res_pend <= 1'b0;
          end else if (w_take_nmi) begin
            r_vec_lo <= NMI_VEC;
            r_setnmi <= 1'b1;
          end else begin
            r_vec_lo <= IRQ_VEC;
            r_setirq <= 1'b1;
          end
        end
        ST_S5: begin
          r_state    <= ST_S6;
          r_setreset <= 1'b0;
          r_setnmi   <= 1'b0;
          r_setirq   <= 1'b0;
          r_vec_lo   <= r_vec_lo + 8'd1;
          r_set_i    <= 1'b1;
        end
        ST_S6: begin
          r_state     <= ST_IDLE;
          r_src       <= SRC_NONE;
          r_busy      <= 1'b0;
          r_pcinc_inh <= 1'b0;
          r_vec_lo    <= 8'h00;
          r_set_i     <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.pcinc_inh = r_pcinc_inh;
  assign bus.push_pch  = r_push_pch;
  assign bus.push_pcl  = r_push_pcl;
  assign bus.push_p    = r_push_p;
  assign bus.bflag     = r_bflag;
  assign bus.wr_inh    = r_wr_inh;
  assign bus.setreset  = r_setreset;
  assign bus.setnmi    = r_setnmi;
  assign bus.setirq    = r_setirq;
  assign bus.vec_lo    = r_vec_lo;
  assign bus.set_i     = r_set_i;

endmodule

`default_nettype wire

// File: tb/tb_int_sequencer.sv
// ---------------------------------------------------------------------------
// tb_int_sequencer : frame-queue model of the interrupt entry sequence
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_int_sequencer;

  typedef struct packed {
    logic       busy;
    logic       pcinc;
    logic       pch;
    logic       pcl;
    logic       p;
    logic       bflag;
    logic       wr;
    logic       sres;
    logic       snmi;
    logic       sirq;
    logic       seti;
    logic [7:0] vec;
  } frame_t;

  localparam int SRC_RES = 1;
  localparam int SRC_NMI = 2;
  localparam int SRC_IRQ = 3;
  localparam int SRC_BRK = 4;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 0;

  int_sequencer_if bus ();

  int_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  frame_t dut_frame;
  assign dut_frame = '{busy: bus.busy, pcinc: bus.pcinc_inh, pch: bus.push_pch,
                       pcl: bus.push_pcl, p: bus.push_p, bflag: bus.bflag,
                       wr: bus.wr_inh, sres: bus.setreset, snmi: bus.setnmi,
                       sirq: bus.setirq, seti: bus.set_i, vec: bus.vec_lo};

  // Model: each accepted request expands into six output frames; an idle
  // cycle always separates sequences.
  frame_t q[$];
  frame_t cur;
  bit     m_res, m_nmi, m_prev, m_edge, m_pend;
  int     m_src;

  task automatic push_seq(input int s);
    frame_t     f;
    logic [7:0] v;
    v = (s == SRC_RES) ? 8'hFC : (s == SRC_NMI) ? 8'hFA : 8'hFE;
    f = '0; f.busy = 1'b1; f.pcinc = 1'b1; f.bflag = (s == SRC_BRK);
    q.push_back(f);
    f.pch = 1'b1; f.wr = (s == SRC_RES);
    q.push_back(f);
    f.pch = 1'b0; f.pcl = 1'b1;
    q.push_back(f);
    f.pcl = 1'b0; f.p = 1'b1;
    q.push_back(f);
    f.p = 1'b0; f.wr = 1'b0; f.bflag = 1'b0; f.vec = v;
    f.sres = (s == SRC_RES); f.snmi = (s == SRC_NMI); f.sirq = (s >= SRC_IRQ);
    q.push_back(f);
    f.sres = 1'b0; f.snmi = 1'b0; f.sirq = 1'b0; f.vec = v + 8'd1; f.seti = 1'b1;
    q.push_back(f);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res  = 1'b1;
      m_nmi  = 1'b0;
      m_prev = 1'b1;
      q.delete();
      cur    = '0;
    end else if (bus.rdy) begin
      m_edge = m_prev && !bus.nmi_n;
      m_prev = bus.nmi_n;
      m_pend = m_nmi | m_edge;
      if (q.size() == 0) begin
        if (cur.busy) cur = '0;
        else begin
          m_src = 0;
          if (m_res) m_src = SRC_RES;
          else if (bus.sync) begin
            if (m_pend) m_src = SRC_NMI;
            else if (bus.brk) m_src = SRC_BRK;
            else if (!bus.irq_n && !bus.iflag) m_src = SRC_IRQ;
          end
          if (m_src != 0) begin
            push_seq(m_src);
            cur = q.pop_front();
          end
        end
      end else begin
        if (q.size() == 2 && m_src != SRC_RES && m_pend) begin
          q[0].vec = 8'hFA; q[0].snmi = 1'b1; q[0].sirq = 1'b0;
          q[1].vec = 8'hFB;
        end
        cur = q.pop_front();
      end
      if (cur.snmi) m_pend = 1'b0;
      if (cur.sres) m_res = 1'b0;
      m_nmi = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (dut_frame !== cur) begin
        n_fail++;
        $display("FAIL frame t=%0t dut=%h model=%h", $time, dut_frame, cur);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.rdy   = 1'b1;
    bus.sync  = 1'b0;
    bus.brk   = 1'b0;
    bus.nmi_n = 1'b1;
    bus.irq_n = 1'b1;
    bus.iflag = 1'b1;
    #1 chk_en = 1;
    step(2);
    chk("reset_busy", bus.busy, 8'd0);
    chk("reset_vec", bus.vec_lo, 8'h00);

    // Power-up RESET sequence
    rst_n = 1'b1;
    step(1); chk("res_s1_busy", bus.busy, 8'd1);
    step(1); chk("res_s2_wrinh", bus.wr_inh, 8'd1); chk("res_s2_pch", bus.push_pch, 8'd1);
    step(3); chk("res_s5_vec", bus.vec_lo, 8'hFC); chk("res_s5_setreset", bus.setreset, 8'd1);
    step(1); chk("res_s6_vec", bus.vec_lo, 8'hFD); chk("res_s6_seti", bus.set_i, 8'd1);
    step(1); chk("res_idle", bus.busy, 8'd0);

    // Unmasked IRQ; irq_n released right after arbitration
    bus.iflag = 1'b0; bus.irq_n = 1'b0; bus.sync = 1'b1;
    step(1); chk("irq_s1_busy", bus.busy, 8'd1);
    bus.sync = 1'b0; bus.irq_n = 1'b1;
    step(4); chk("irq_s5_vec", bus.vec_lo, 8'hFE); chk("irq_s5_setirq", bus.setirq, 8'd1);
    step(1); chk("irq_s6_vec", bus.vec_lo, 8'hFF);
    step(1);

    // Masked IRQ
    bus.iflag = 1'b1; bus.irq_n = 1'b0; bus.sync = 1'b1;
    step(1); chk("irq_masked_busy", bus.busy, 8'd0);
    bus.sync = 1'b0; bus.irq_n = 1'b1;

    // BRK ignores iflag
    bus.brk = 1'b1; bus.sync = 1'b1;
    step(1); bus.brk = 1'b0; bus.sync = 1'b0;
    step(3); chk("brk_s4_bflag", bus.bflag, 8'd1); chk("brk_s4_pushp", bus.push_p, 8'd1);
    step(1); chk("brk_s5_setirq", bus.setirq, 8'd1); chk("brk_s5_vec", bus.vec_lo, 8'hFE);
    step(2);

    // NMI edge in S3 hijacks an IRQ sequence
    bus.iflag = 1'b0; bus.irq_n = 1'b0; bus.sync = 1'b1;
    step(1); bus.sync = 1'b0; bus.irq_n = 1'b1;
    step(2); bus.nmi_n = 1'b0;
    step(2); chk("hij_s5_setnmi", bus.setnmi, 8'd1); chk("hij_s5_setirq", bus.setirq, 8'd0);
    chk("hij_s5_vec", bus.vec_lo, 8'hFA);
    step(1); chk("hij_s6_vec", bus.vec_lo, 8'hFB);
    step(1);
    bus.iflag = 1'b1; bus.sync = 1'b1;
    step(1); chk("nmi_level_no_retrigger", bus.busy, 8'd0);
    bus.sync = 1'b0; bus.nmi_n = 1'b1;
    step(1);

    // Simultaneous NMI edge and IRQ: NMI first, then IRQ
    bus.iflag = 1'b0; bus.irq_n = 1'b0; bus.sync = 1'b1; bus.nmi_n = 1'b0;
    step(1); bus.sync = 1'b0;
    step(4); chk("simul_nmi_setnmi", bus.setnmi, 8'd1); chk("simul_nmi_vec", bus.vec_lo, 8'hFA);
    step(2); bus.sync = 1'b1;
    step(1); chk("simul_irq_busy", bus.busy, 8'd1);
    bus.sync = 1'b0;
    step(4); chk("simul_irq_setirq", bus.setirq, 8'd1);
    bus.irq_n = 1'b1;
    step(2); bus.nmi_n = 1'b1;

    // rdy stall in S4
    bus.irq_n = 1'b0; bus.sync = 1'b1;
    step(1); bus.sync = 1'b0; bus.irq_n = 1'b1;
    step(3); bus.rdy = 1'b0;
    step(3); chk("stall_pushp", bus.push_p, 8'd1); chk("stall_no_s5", bus.setirq, 8'd0);
    bus.rdy = 1'b1;
    step(1); chk("stall_s5_setirq", bus.setirq, 8'd1);
    step(2);

    // Reset pulse in S3 restarts with a RESET sequence
    bus.irq_n = 1'b0; bus.sync = 1'b1;
    step(1); bus.sync = 1'b0; bus.irq_n = 1'b1;
    step(2); rst_n = 1'b0;
    #1 chk("rstpulse_busy", bus.busy, 8'd0); chk("rstpulse_pcl", bus.push_pcl, 8'd0);
    step(1); rst_n = 1'b1;
    step(1); chk("rstpulse_s1_busy", bus.busy, 8'd1);
    step(4); chk("rstpulse_s5_vec", bus.vec_lo, 8'hFC); chk("rstpulse_s5_setreset", bus.setreset, 8'd1);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
